// File: rtl/ecc_pkg.sv
// +----------------------------------------------------------------------------+
// | ecc_pkg                                                                    |
// | Shared types and constants for the ECC operand loader/unloader.            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package ecc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_UNLOAD = 2'd3
  } ecc_state_e;

  localparam int unsigned c_def_nibble_w = 4;
  localparam int unsigned c_def_word_w   = 32;
  localparam int unsigned c_def_num_in   = 5;
  localparam int unsigned c_def_num_out  = 2;

  // Operand channel order on din / core_ops.
  localparam int unsigned CH_PRIME = 0;
  localparam int unsigned CH_PX    = 1;
  localparam int unsigned CH_PY    = 2;
  localparam int unsigned CH_A     = 3;
  localparam int unsigned CH_K     = 4;

endpackage

`default_nettype wire

// File: rtl/ecc_nibble_shreg.sv
// +----------------------------------------------------------------------------+
// | ecc_nibble_shreg                                                           |
// | One WORD_W register: nibble shift-in (MSB first), clear, parallel load.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ecc_nibble_shreg
  import ecc_pkg::*;
#(
  parameter int unsigned NIBBLE_W = c_def_nibble_w,
  parameter int unsigned WORD_W   = c_def_word_w
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                shift_i,
  input  logic [NIBBLE_W-1:0] nib_i,
  input  logic                load_i,
  input  logic [WORD_W-1:0]   word_i,
  output logic [WORD_W-1:0]   word_o
);

  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;
  logic [WORD_W-1:0] w_base;

  // Clear combined with shift yields {0.., nib_i}: the first beat of a fresh load.
  always_comb begin
    w_base = clr_i ? '0 : word_q;
    word_d = w_base;
    if (load_i) begin
      word_d = word_i;
    end else if (shift_i) begin
      word_d = {w_base[WORD_W-NIBBLE_W-1:0], nib_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

`default_nettype wire

// File: rtl/ecc_operand_io.sv
// +----------------------------------------------------------------------------+
// | ecc_operand_io                                                             |
// | Nibble-serial operand loader / result unloader around the ECC core.        |
// | Optional range check on prime/Px/Py: define ECC_IO_RANGE_CHECK_EN.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ecc_operand_io
  import ecc_pkg::*;
#(
  parameter int unsigned NIBBLE_W = c_def_nibble_w,
  parameter int unsigned WORD_W   = c_def_word_w,
  parameter int unsigned NUM_IN   = c_def_num_in,
  parameter int unsigned NUM_OUT  = c_def_num_out
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid,
  input  logic [NUM_IN*NIBBLE_W-1:0] din,
  output logic                       ready,
  output logic                       core_start,
  output logic [NUM_IN*WORD_W-1:0]   core_ops,
  input  logic                       core_done,
  input  logic [NUM_OUT*WORD_W-1:0]  core_res,
  output logic                       out_valid,
  output logic [NIBBLE_W-1:0]        dout,
  output logic                       err
);

  localparam int unsigned c_beats = WORD_W / NIBBLE_W;
  localparam int unsigned c_cnt_w = (c_beats * NUM_OUT > 1) ? $clog2(c_beats * NUM_OUT) : 1;
  localparam logic [c_cnt_w-1:0] c_last_in  = c_cnt_w'(c_beats - 1);
  localparam logic [c_cnt_w-1:0] c_last_out = c_cnt_w'(c_beats * NUM_OUT - 1);

  ecc_state_e         state_q;
  logic [c_cnt_w-1:0] cnt_q;
  logic               ready_q;
  logic               start_q;
  logic               first_q;
  logic               bad_q;
  logic               err_q;
  logic               out_valid_q;

  logic [WORD_W-1:0]  w_ops [NUM_IN];
  logic [WORD_W-1:0]  w_res [NUM_OUT];

  logic w_beat;
  logic w_op_clr;
  logic w_run_fail;
  logic w_res_load;
  logic w_res_shift;
  logic w_bad_next;

  assign w_beat      = valid && ready_q;
  assign w_op_clr    = w_beat && (state_q == ST_IDLE);
  assign w_run_fail  = (state_q == ST_RUN) && first_q && bad_q;
  assign w_res_load  = (state_q == ST_RUN) && core_done && !w_run_fail;
  assign w_res_shift = (state_q == ST_UNLOAD);

`ifdef ECC_IO_RANGE_CHECK_EN
  // Judged on the operand values the final beat is about to complete, so the
  // start pulse can be withheld in the very first RUN cycle.
  logic [WORD_W-1:0] w_prime_nx;
  logic [WORD_W-1:0] w_px_nx;
  logic [WORD_W-1:0] w_py_nx;

  assign w_prime_nx = {w_ops[CH_PRIME][WORD_W-NIBBLE_W-1:0], din[CH_PRIME*NIBBLE_W +: NIBBLE_W]};
  assign w_px_nx    = {w_ops[CH_PX][WORD_W-NIBBLE_W-1:0],    din[CH_PX*NIBBLE_W +: NIBBLE_W]};
  assign w_py_nx    = {w_ops[CH_PY][WORD_W-NIBBLE_W-1:0],    din[CH_PY*NIBBLE_W +: NIBBLE_W]};
  assign w_bad_next = (w_prime_nx == '0) || (w_px_nx >= w_prime_nx) || (w_py_nx >= w_prime_nx);
`else
  assign w_bad_next = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      start_q     <= 1'b0;
      first_q     <= 1'b0;
      bad_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      first_q <= 1'b0;
      if (w_beat) begin
        err_q <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (w_beat) begin
            state_q <= ST_LOAD;
            cnt_q   <= c_cnt_w'(1);
          end
        end
        ST_LOAD: begin
          if (w_beat) begin
            if (cnt_q == c_last_in) begin
              state_q <= ST_RUN;
              ready_q <= 1'b0;
              cnt_q   <= '0;
              start_q <= !w_bad_next;
              first_q <= 1'b1;
              bad_q   <= w_bad_next;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_run_fail) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            bad_q   <= 1'b0;
          end else if (core_done) begin
            state_q     <= ST_UNLOAD;
            out_valid_q <= 1'b1;
          end
        end
        ST_UNLOAD: begin
          if (cnt_q == c_last_out) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    ecc_nibble_shreg #(
      .NIBBLE_W (NIBBLE_W),
      .WORD_W   (WORD_W)
    ) u_op_reg (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (w_op_clr),
      .shift_i (w_beat),
      .nib_i   (din[i*NIBBLE_W +: NIBBLE_W]),
      .load_i  (1'b0),
      .word_i  ({WORD_W{1'b0}}),
      .word_o  (w_ops[i])
    );
    assign core_ops[i*WORD_W +: WORD_W] = w_ops[i];
  end

  // Result words form one long chain: word j+1 feeds word j, so dout is always
  // the top nibble of word 0 and the chain drains to zero after unloading.
  logic [NUM_OUT*(WORD_W-NIBBLE_W)-1:0] w_unused_res;

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    logic [NIBBLE_W-1:0] w_chain;
    if (j == NUM_OUT - 1) begin : g_tail
      assign w_chain = '0;
    end else begin : g_link
      assign w_chain = w_res[j+1][WORD_W-1 -: NIBBLE_W];
    end

    ecc_nibble_shreg #(
      .NIBBLE_W (NIBBLE_W),
      .WORD_W   (WORD_W)
    ) u_res_reg (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (1'b0),
      .shift_i (w_res_shift),
      .nib_i   (w_chain),
      .load_i  (w_res_load),
      .word_i  (core_res[j*WORD_W +: WORD_W]),
      .word_o  (w_res[j])
    );
    assign w_unused_res[j*(WORD_W-NIBBLE_W) +: (WORD_W-NIBBLE_W)] = w_res[j][WORD_W-NIBBLE_W-1:0];
  end

  assign ready      = ready_q;
  assign core_start = start_q;
  assign out_valid  = out_valid_q;
  assign dout       = w_res[0][WORD_W-1 -: NIBBLE_W];
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ecc_operand_io.sv
// +----------------------------------------------------------------------------+
// | tb_ecc_operand_io                                                          |
// | Directed + randomized bench for ecc_operand_io (4-bit and 8-bit builds).   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ecc_operand_io;
  import ecc_pkg::*;

  localparam int NW = 4, WW = 32, NI = 5, NO = 2, BEATS = WW / NW;
  localparam int NW8 = 8, WW8 = 64, BEATS8 = WW8 / NW8;

  logic clk = 1'b0;
  logic rst, valid, core_done;
  logic [NI*NW-1:0] din;
  logic [NO*WW-1:0] core_res;
  logic ready, core_start, out_valid, err;
  logic [NI*WW-1:0] core_ops;
  logic [NW-1:0] dout;

  logic v8, done8, ready8, start8, ov8, err8;
  logic [NI*NW8-1:0] din8;
  logic [NO*WW8-1:0] res8;
  logic [NI*WW8-1:0] ops8;
  logic [NW8-1:0] dout8;

  ecc_operand_io dut (
    .clk(clk), .rst(rst), .valid(valid), .din(din), .ready(ready),
    .core_start(core_start), .core_ops(core_ops), .core_done(core_done),
    .core_res(core_res), .out_valid(out_valid), .dout(dout), .err(err)
  );

  ecc_operand_io #(.NIBBLE_W(NW8), .WORD_W(WW8), .NUM_IN(NI), .NUM_OUT(NO)) dut8 (
    .clk(clk), .rst(rst), .valid(v8), .din(din8), .ready(ready8),
    .core_start(start8), .core_ops(ops8), .core_done(done8),
    .core_res(res8), .out_valid(ov8), .dout(dout8), .err(err8)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0, n_start = 0, n_ov = 0;
  logic [31:0] cur_ops [NI];
  logic [31:0] cur_res [NO];

  always @(posedge clk) begin
    #2;
    if (core_start) n_start++;
    if (out_valid) n_ov++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NI*WW-1:0] exp_ops();
    logic [NI*WW-1:0] v;
    for (int i = 0; i < NI; i++) v[i*WW +: WW] = cur_ops[i];
    return v;
  endfunction

  task automatic rand_ops();
    cur_ops[CH_PRIME] = $urandom | 32'd1;
    cur_ops[CH_PX]    = $urandom % cur_ops[CH_PRIME];
    cur_ops[CH_PY]    = $urandom % cur_ops[CH_PRIME];
    cur_ops[CH_A]     = $urandom;
    cur_ops[CH_K]     = $urandom;
    cur_res[0]        = $urandom;
    cur_res[1]        = $urandom;
  endtask

  // Feeds nbeats beats MSB nibble first, with gap idle cycles before each beat.
  task automatic load(input int nbeats, input int gap);
    logic [31:0] r;
    for (int b = 0; b < nbeats; b++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        r = $urandom;
        valid = 1'b0;
        din = r[NI*NW-1:0];
      end
      @(negedge clk);
      valid = 1'b1;
      for (int i = 0; i < NI; i++) din[i*NW +: NW] = NW'(cur_ops[i] >> (WW - NW*(b+1)));
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic txn(input int gap, input int lat);
    int s0, o0;
    logic [31:0] r;
    logic [NW-1:0] q [$];
    s0 = n_start;
    o0 = n_ov;
    load(BEATS, gap);
    chk("start_after_last_beat", core_start, 1);
    chk("ready_low_in_run", ready, 0);
    chk("core_ops", core_ops, exp_ops());
    for (int c = 0; c < lat; c++) begin
      r = $urandom;
      valid = r[0];
      din = r[NI*NW-1:0];
      @(negedge clk);
      chk("start_single_cycle", core_start, 0);
    end
    core_done = 1'b1;
    for (int j = 0; j < NO; j++) core_res[j*WW +: WW] = cur_res[j];
    for (int j = 0; j < NO; j++)
      for (int n = 0; n < BEATS; n++) q.push_back(NW'(cur_res[j] >> (WW - NW*(n+1))));
    @(negedge clk);
    core_done = 1'b0;
    core_res = {$urandom, $urandom};
    for (int k = 0; k < BEATS*NO; k++) begin
      chk("out_valid", out_valid, 1);
      chk("dout", dout, q.pop_front());
      r = $urandom;
      valid = r[0];
      din = r[NI*NW-1:0];
      @(negedge clk);
    end
    valid = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("ready_back", ready, 1);
    chk("ops_hold", core_ops, exp_ops());
    chk("start_count", n_start - s0, 1);
    chk("out_count", n_ov - o0, BEATS*NO);
    chk("err_clear", err, 0);
  endtask

  initial begin
    logic [63:0] ops8_m [NI];
    logic [63:0] res8_m [NO];
    logic [NI*WW8-1:0] e8;
    int s0, o0;

    rst = 1'b1; valid = 1'b0; din = '0; core_done = 1'b0; core_res = '0;
    v8 = 1'b0; din8 = '0; done8 = 1'b0; res8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_ops", core_ops, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // Directed example vector, back to back and with beats every 3rd cycle.
    cur_ops[CH_PRIME] = 32'h17; cur_ops[CH_PX] = 32'h3; cur_ops[CH_PY] = 32'hA;
    cur_ops[CH_A] = 32'h1; cur_ops[CH_K] = 32'h5;
    cur_res[0] = 32'h11; cur_res[1] = 32'h14;
    txn(0, 3);
    txn(2, 0);

    for (int t = 0; t < 4; t++) begin
      rand_ops();
      txn($urandom_range(0, 2), $urandom_range(0, 4));
    end

    // Reset in the middle of a load.
    rand_ops();
    load(5, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", ready, 1);
    chk("midrst_core_start", core_start, 0);
    chk("midrst_core_ops", core_ops, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_err", err, 0);
    rst = 1'b0;
    rand_ops();
    txn(0, 2);

    // Px >= prime.
    cur_ops[CH_PRIME] = 32'h17; cur_ops[CH_PX] = 32'h20; cur_ops[CH_PY] = 32'h5;
    cur_ops[CH_A] = 32'h1; cur_ops[CH_K] = 32'h2;
    s0 = n_start;
    o0 = n_ov;
    load(BEATS, 0);
`ifdef ECC_IO_RANGE_CHECK_EN
    chk("range_no_start", core_start, 0);
    @(negedge clk);
    chk("range_err_set", err, 1);
    chk("range_ready_idle", ready, 1);
    repeat (3) @(negedge clk);
    chk("range_err_held", err, 1);
    chk("range_start_count", n_start - s0, 0);
    chk("range_no_unload", n_ov - o0, 0);
    rand_ops();
    txn(1, 1);
`else
    chk("norange_start", core_start, 1);
    chk("norange_err", err, 0);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    repeat (BEATS*NO) @(negedge clk);
    chk("norange_ready_back", ready, 1);
    chk("norange_start_count", n_start - s0, 1);
    chk("norange_out_count", n_ov - o0, BEATS*NO);
`endif

    // Byte-wide, 64-bit build.
    for (int i = 0; i < NI; i++) ops8_m[i] = {$urandom, $urandom};
    ops8_m[CH_PRIME] = ops8_m[CH_PRIME] | 64'd1;
    ops8_m[CH_PX] = ops8_m[CH_PX] % ops8_m[CH_PRIME];
    ops8_m[CH_PY] = ops8_m[CH_PY] % ops8_m[CH_PRIME];
    res8_m[0] = {$urandom, $urandom};
    res8_m[1] = {$urandom, $urandom};
    for (int i = 0; i < NI; i++) e8[i*WW8 +: WW8] = ops8_m[i];
    for (int b = 0; b < BEATS8; b++) begin
      @(negedge clk);
      v8 = 1'b1;
      for (int i = 0; i < NI; i++) din8[i*NW8 +: NW8] = NW8'(ops8_m[i] >> (WW8 - NW8*(b+1)));
    end
    @(negedge clk);
    v8 = 1'b0;
    chk("w8_start", start8, 1);
    chk("w8_core_ops", ops8, e8);
    done8 = 1'b1;
    res8 = {res8_m[1], res8_m[0]};
    @(negedge clk);
    done8 = 1'b0;
    for (int k = 0; k < BEATS8*NO; k++) begin
      chk("w8_out_valid", ov8, 1);
      chk("w8_dout", dout8, NW8'(res8_m[k / BEATS8] >> (WW8 - NW8*((k % BEATS8) + 1))));
      @(negedge clk);
    end
    chk("w8_ready_back", ready8, 1);
    chk("w8_out_valid_drop", ov8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ecc_operand_io.md
# ecc_operand_io

Parametrised operand loader and result unloader for the ECC point-multiplication datapath. Collects NUM_IN operands (prime, Px, Py, a, k) over a narrow nibble-serial bus into WORD_W-bit registers. It then starts the scalar-multiplication core and captures its NUM_OUT results (kP x, kP y). Finally it streams those results back out over the same narrow width with a valid strobe. It sits between the chip pins and the Control/GFAU core.

## Interface
- NIBBLE_W, 4: serial beat width per channel
- WORD_W, 32: operand/result width; must be a multiple of NIBBLE_W
- NUM_IN, 5: input channels, ordered prime, Px, Py, a, k
- NUM_OUT, 2: result words, ordered x, y
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- valid  in  1  input beat qualifier
- din  in  NUM_IN*NIBBLE_W  one nibble per channel; channel i at bits [i*NIBBLE_W +: NIBBLE_W]
- ready  out  1  block accepts input beats
- core_start  out  1  one-cycle start pulse to core
- core_ops  out  NUM_IN*WORD_W  assembled operands; channel i at [i*WORD_W +: WORD_W]
- core_done  in  1  one-cycle pulse; results valid that cycle
- core_res  in  NUM_OUT*WORD_W  results, word j at [j*WORD_W +: WORD_W]
- out_valid  out  1  dout carries a result nibble
- dout  out  NIBBLE_W  serial result nibble
- err  out  1  range-check failure flag (see Configuration)

## Operation
- BEATS = WORD_W/NIBBLE_W, counter width clog2(BEATS*NUM_OUT).
- States:
  - IDLE: ready=1. A beat (valid&&ready) shifts into the operand registers and moves to LOAD; operands are cleared on IDLE→LOAD.
  - LOAD: ready=1. Each beat does reg_i <= {reg_i[WORD_W-NIBBLE_W-1:0], din_i}, MSB nibble first, and increments the beat counter. Gaps (valid=0) hold state. The BEATS-th beat moves to RUN.
  - RUN: ready=0. core_start pulses on the first RUN cycle. The block waits for core_done, latches core_res into result registers and moves to UNLOAD.
  - UNLOAD: ready=0. Emits BEATS*NUM_OUT consecutive nibbles with out_valid=1, word 0 first, MSB nibble first. There is no backpressure. After the last nibble it returns to IDLE.
- core_ops is driven from the operand registers continuously and is stable from core_start until the block leaves RUN.
- valid is ignored while ready=0. core_done is ignored outside RUN.
- rst in any state clears all registers and returns to IDLE. The next load starts from an empty counter.

## Timing
- Reset values: ready=1, core_start=0, core_ops=0, out_valid=0, dout=0, err=0.
- Beat-to-start: core_start is asserted exactly 1 cycle after the cycle accepting the final beat.
- core_done to first dout nibble: 1 cycle, registered output.
- ready falls in the cycle after the final beat. ready rises in the cycle after the last out_valid.
- A valid in the last UNLOAD cycle is not accepted.
- Minimum transaction: BEATS + 1 + core latency + 1 + BEATS*NUM_OUT cycles.

## Configuration
- ECC_IO_RANGE_CHECK_EN defined:
  - In the first RUN cycle, the block checks prime!=0, Px<prime and Py<prime.
  - On failure it sets err=1, suppresses core_start and returns to IDLE next cycle without unloading.
  - err stays set until the next accepted beat or rst.
- ECC_IO_RANGE_CHECK_EN undefined: no comparators, err tied 0, core_start always issued.

## Structure
- Shared package ecc_pkg holds:
  - state enum (IDLE, LOAD, RUN, UNLOAD)
  - default NIBBLE_W/WORD_W constants
  - channel index constants CH_PRIME, CH_PX, CH_PY, CH_A, CH_K
- Sub-module ecc_nibble_shreg: one WORD_W shift register with load-enable, clear and parallel load. It is instantiated NUM_IN times for input and NUM_OUT times for output (parallel-load mode).

## Test plan
- Defaults. 8 beats load prime=0x00000017, Px=0x00000003, Py=0x0000000A, a=0x00000001, k=0x00000005 → core_ops matches, core_start one pulse 1 cycle after beat 8.
- core_done with res={0x00000011,0x00000014} → out_valid for 16 cycles, dout sequence 0,0,0,0,0,0,1,1 then 0,0,0,0,0,0,1,4; ready returns 1 next cycle.
- Load with valid gaps (beats every 3rd cycle) → identical core_ops; valid during RUN/UNLOAD has no effect on operands.
- rst asserted after beat 5 → all outputs reset values next cycle; a fresh 8-beat load completes correctly.
- NIBBLE_W=8, WORD_W=64, NUM_OUT=2 → 8 load beats, 16 output beats, bytes MSB first.
- With ECC_IO_RANGE_CHECK_EN: Px=0x00000020, prime=0x00000017 → err=1, no core_start, no out_valid, back to IDLE. Without the macro, err stays 0 and core_start is issued.
